// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants and types for the interrupt controller.
//   Register map (ADDR), FSM state encoding, and the CTRL bit holding GIE.
package int_ctrl_pkg;

  localparam logic [1:0] A_MASK  = 2'd0;
  localparam logic [1:0] A_PEND  = 2'd1;
  localparam logic [1:0] A_VBASE = 2'd2;
  localparam logic [1:0] A_CTRL  = 2'd3;

  localparam int GIE_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_CALL,
    S_SERVICE
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: combinational priority encoder, lowest set index wins.
//   req_i   : request vector
//   valid_o : any request set
//   id_o    : index of the lowest set request (0 when none)
module int_prio_enc #(
  parameter int NIRQ = 8
) (
  input  logic [NIRQ-1:0] req_i,
  output logic            valid_o,
  output logic [3:0]      id_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    id_o    = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller for the microcoded control unit.
//   Latches rising edges of IRQ into PEND, masks them, picks the lowest
//   enabled id, holds fetch (interrupt) for DRAIN cycles, pulses CallInt
//   once, then tracks call_in/ret_in nesting to find the end of the ISR.
//   Ports:
//     CLK, nRST          clock, async active-low reset
//     IRQ                peripheral request lines (rising-edge sensitive)
//     WE, ADDR, DIN      register write port; DOUT combinational read
//     call_in, ret_in    control unit call/ret indications
//     interrupt, CallInt fetch hold and forced-call pulse
//     VECTOR, ACTIVE_ID  ISR address and id in service
//   Build option: INT_CTRL_NESTING_EN enables preemption by a lower id
//   during SERVICE using a 4-entry {id, depth} stack.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NIRQ   = 8,
  parameter int DW     = 16,
  parameter int DRAIN  = 1,
  parameter int VSHIFT = 2,
  parameter int DEPTHW = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NIRQ-1:0] IRQ,
  input  logic            WE,
  input  logic [1:0]      ADDR,
  input  logic [DW-1:0]   DIN,
  output logic [DW-1:0]   DOUT,
  input  logic            call_in,
  input  logic            ret_in,
  output logic            interrupt,
  output logic            CallInt,
  output logic [DW-1:0]   VECTOR,
  output logic [3:0]      ACTIVE_ID
);

  localparam int CW = $clog2(DRAIN + 2);

  logic [NIRQ-1:0]   irq_q, pend_q, mask_q;
  logic [NIRQ-1:0]   rise, w1c, take_mask, elig;
  logic [DW-1:0]     vbase_q, vec_q, vec_d, vec_new;
  logic              gie_q;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        id_q, id_d;
  logic [DEPTHW-1:0] depth_q, depth_d;
  logic              take, isr_end;
  logic              enc_vld;
  logic [3:0]        enc_id;

  assign rise      = IRQ & ~irq_q;
  assign w1c       = (WE && ADDR == A_PEND) ? DIN[NIRQ-1:0] : '0;
  assign take_mask = take ? (NIRQ'(1) << enc_id) : '0;
  assign elig      = pend_q & mask_q & {NIRQ{gie_q}};
  assign vec_new   = vbase_q + (DW'(enc_id) << VSHIFT);
  assign isr_end   = ret_in && !call_in && depth_q == '0;

  int_prio_enc #(.NIRQ(NIRQ)) u_enc (
    .req_i   (elig),
    .valid_o (enc_vld),
    .id_o    (enc_id)
  );

`ifdef INT_CTRL_NESTING_EN
  logic [3:0]        stk_id_q  [4];
  logic [DEPTHW-1:0] stk_dep_q [4];
  logic [2:0]        sp_q;
  logic              push, pop;
  logic [1:0]        top;

  assign top = sp_q[1:0] - 2'd1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sp_q <= '0;
      for (int i = 0; i < 4; i++) begin
        stk_id_q[i]  <= '0;
        stk_dep_q[i] <= '0;
      end
    end else if (push) begin
      stk_id_q[sp_q[1:0]]  <= id_q;
      stk_dep_q[sp_q[1:0]] <= depth_d;
      sp_q <= sp_q + 3'd1;
    end else if (pop) begin
      sp_q <= sp_q - 3'd1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    depth_d = depth_q;
    vec_d   = vec_q;
    take    = 1'b0;
`ifdef INT_CTRL_NESTING_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (enc_vld) begin
          take    = 1'b1;
          id_d    = enc_id;
          vec_d   = vec_new;
          cnt_d   = CW'(DRAIN);
          state_d = (DRAIN == 0) ? S_CALL : S_HOLD;
        end
      end
      S_HOLD: begin
        // Counter loaded with DRAIN on entry, so HOLD lasts DRAIN cycles.
        if (cnt_q <= CW'(1)) state_d = S_CALL;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      S_CALL: begin
        depth_d = '0;
        state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (isr_end) begin
`ifdef INT_CTRL_NESTING_EN
          if (sp_q != 3'd0) begin
            pop     = 1'b1;
            id_d    = stk_id_q[top];
            depth_d = stk_dep_q[top];
            vec_d   = vbase_q + (DW'(stk_id_q[top]) << VSHIFT);
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else if (ret_in && !call_in) begin
          depth_d = depth_q - 1'b1;
        end else if (call_in && !ret_in) begin
          if (depth_q != '1) depth_d = depth_q + 1'b1;
        end
`ifdef INT_CTRL_NESTING_EN
        // Preemption saves the depth including this cycle's call/ret.
        if (!isr_end && enc_vld && enc_id < id_q && sp_q != 3'd4) begin
          push    = 1'b1;
          take    = 1'b1;
          id_d    = enc_id;
          vec_d   = vec_new;
          cnt_d   = CW'(DRAIN);
          state_d = (DRAIN == 0) ? S_CALL : S_HOLD;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // All-ones so a line already high at reset release is not an edge.
      irq_q   <= '1;
      pend_q  <= '0;
      mask_q  <= '0;
      vbase_q <= '0;
      gie_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      depth_q <= '0;
      vec_q   <= '0;
    end else begin
      irq_q   <= IRQ;
      // A new edge wins over a same-cycle W1C or service take.
      pend_q  <= (pend_q & ~w1c & ~take_mask) | rise;
      if (WE) begin
        case (ADDR)
          A_MASK:  mask_q  <= DIN[NIRQ-1:0];
          A_VBASE: vbase_q <= DIN;
          A_CTRL:  gie_q   <= DIN[GIE_BIT];
          default: ;
        endcase
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      depth_q <= depth_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    DOUT = '0;
    case (ADDR)
      A_MASK:  DOUT = DW'(mask_q);
      A_PEND:  DOUT = DW'(pend_q);
      A_VBASE: DOUT = vbase_q;
      default: DOUT = DW'(gie_q);
    endcase
  end

  assign interrupt = (state_q == S_HOLD) || (state_q == S_CALL);
  assign CallInt   = (state_q == S_CALL);
  assign VECTOR    = vec_q;
  assign ACTIVE_ID = (state_q == S_IDLE) ? 4'd0 : id_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [7:0]  IRQ;
  logic        WE;
  logic [1:0]  ADDR;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        call_in, ret_in;
  logic        interrupt, CallInt;
  logic [15:0] VECTOR;
  logic [3:0]  ACTIVE_ID;

  int n_assert = 0;
  int n_fail   = 0;

  int_ctrl dut (
    .CLK(CLK), .nRST(nRST), .IRQ(IRQ), .WE(WE), .ADDR(ADDR), .DIN(DIN),
    .DOUT(DOUT), .call_in(call_in), .ret_in(ret_in), .interrupt(interrupt),
    .CallInt(CallInt), .VECTOR(VECTOR), .ACTIVE_ID(ACTIVE_ID)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    ADDR = a; DIN = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    ADDR = a;
    #1;
    chk(tag, DOUT, exp);
  endtask

  initial begin
    nRST = 1'b0; IRQ = 8'h08; WE = 1'b0; ADDR = 2'd0; DIN = '0;
    call_in = 1'b0; ret_in = 1'b0;
    #12;
    chk("rst_interrupt", interrupt, 0);
    chk("rst_callint", CallInt, 0);
    chk("rst_vector", VECTOR, 0);
    chk("rst_active_id", ACTIVE_ID, 0);
    rd("rst_pend", 2'd1, 16'h0000);
    rd("rst_mask", 2'd0, 16'h0000);
    @(posedge CLK); #1;
    nRST = 1'b1;
    tick(); tick();
    rd("no_edge_after_rst", 2'd1, 16'h0000);
    IRQ = 8'h00;
    tick();

    // single request on IRQ[3]
    wr(2'd3, 16'h0001);
    wr(2'd0, 16'h0008);
    wr(2'd2, 16'h0100);
    rd("ctrl_gie", 2'd3, 16'h0001);
    rd("vbase_rd", 2'd2, 16'h0100);
    IRQ = 8'h08;
    tick();
    chk("irq3_not_yet", interrupt, 0);
    ADDR = 2'd1; #1;
    chk("irq3_pend", DOUT, 16'h0008);
    tick();
    chk("irq3_hold_int", interrupt, 1);
    chk("irq3_hold_ci", CallInt, 0);
    chk("irq3_vector", VECTOR, 16'h010C);
    chk("irq3_active", ACTIVE_ID, 3);
    rd("irq3_pend_clr", 2'd1, 16'h0000);
    tick();
    chk("irq3_call_int", interrupt, 1);
    chk("irq3_call_ci", CallInt, 1);
    tick();
    chk("irq3_svc_int", interrupt, 0);
    chk("irq3_svc_ci", CallInt, 0);
    chk("irq3_svc_vec", VECTOR, 16'h010C);
    chk("irq3_svc_id", ACTIVE_ID, 3);
    IRQ = 8'h00;

    // nesting depth tracking in SERVICE
    call_in = 1'b1; tick(); tick();
    call_in = 1'b0; ret_in = 1'b1; tick(); tick();
    ret_in = 1'b0;
    chk("depth_still_svc", ACTIVE_ID, 3);
    call_in = 1'b1; ret_in = 1'b1; tick();
    call_in = 1'b0; ret_in = 1'b0;
    chk("callret_same_cycle", ACTIVE_ID, 3);
    ret_in = 1'b1; tick();
    ret_in = 1'b0;
    chk("isr_end_idle", ACTIVE_ID, 0);
    chk("isr_end_int", interrupt, 0);

    // simultaneous IRQ[5] and IRQ[2]
    wr(2'd0, 16'h0024);
    IRQ = 8'h24;
    ADDR = 2'd1;
    tick();
    chk("two_pend", DOUT, 16'h0024);
    tick();
    chk("two_first_id", ACTIVE_ID, 2);
    chk("two_first_vec", VECTOR, 16'h0108);
    chk("two_left_pend", DOUT, 16'h0020);
    tick();
    chk("two_first_call", CallInt, 1);
    tick();
    ret_in = 1'b1; tick();
    ret_in = 1'b0;
    chk("two_first_end", ACTIVE_ID, 0);
    tick();
    chk("two_second_id", ACTIVE_ID, 5);
    chk("two_second_vec", VECTOR, 16'h0114);
    chk("two_second_int", interrupt, 1);
    tick(); tick();
    ret_in = 1'b1; tick();
    ret_in = 1'b0;
    chk("two_second_end", ACTIVE_ID, 0);
    IRQ = 8'h00;

    // masked request stays pending, fires on unmask
    wr(2'd0, 16'h0000);
    IRQ = 8'h02;
    tick(); tick();
    chk("masked_no_int", interrupt, 0);
    rd("masked_pend", 2'd1, 16'h0002);
    wr(2'd0, 16'h0002);
    tick();
    chk("unmask_id", ACTIVE_ID, 1);
    chk("unmask_int", interrupt, 1);
    chk("unmask_vec", VECTOR, 16'h0104);
    tick(); tick();
    ret_in = 1'b1; tick();
    ret_in = 1'b0;
    chk("unmask_end", ACTIVE_ID, 0);

    // W1C colliding with a new edge keeps the bit; plain W1C clears
    wr(2'd0, 16'h0000);
    IRQ = 8'h00;
    tick();
    IRQ = 8'h02;
    wr(2'd1, 16'h0002);
    rd("w1c_edge_wins", 2'd1, 16'h0002);
    wr(2'd1, 16'h0002);
    rd("w1c_clears", 2'd1, 16'h0000);

    // GIE low in IDLE blocks entry
    wr(2'd3, 16'h0000);
    IRQ = 8'h00;
    tick();
    IRQ = 8'h02;
    tick();
    wr(2'd0, 16'h0002);
    tick(); tick();
    chk("gie_off_no_int", interrupt, 0);
    rd("gie_off_ctrl", 2'd3, 16'h0000);
    wr(2'd3, 16'h0001);
    tick();
    chk("gie_on_hold", interrupt, 1);

    // async reset in HOLD
    nRST = 1'b0;
    #1;
    chk("rst_hold_int", interrupt, 0);
    chk("rst_hold_ci", CallInt, 0);
    chk("rst_hold_id", ACTIVE_ID, 0);
    tick();
    nRST = 1'b1;
    tick(); tick();
    chk("rst_after_int", interrupt, 0);
    chk("rst_after_id", ACTIVE_ID, 0);
    rd("rst_after_pend", 2'd1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
